// File: rtl/decoder_nbit_strobe.sv
`default_nettype none
// ============================================================================
// Module      : decoder_nbit_strobe
// Description : Registered N-bit decoder with a timed strobe. A request
//               (addr, mode, len) is accepted over valid/ready, the one-hot
//               or thermometer pattern is held on y for len cycles, then a
//               fixed idle gap is forced before the next request.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_nbit_strobe #(
    parameter int N       = 3,
    parameter int LEN_W   = 8,
    parameter int GAP_LEN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [N-1:0]      req_addr,
    input  logic              req_mode,
    input  logic [LEN_W-1:0]  req_len,
    output logic [2**N-1:0]   y,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int W     = 2**N;
    // The gap counter only has to hold GAP_LEN-1; keep it at least one bit wide.
    localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [GAP_W-1:0] c_gap_load = (GAP_LEN > 0) ? GAP_W'(GAP_LEN - 1) : '0;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACTIVE = 2'd1;
    localparam logic [1:0] c_GAP    = 2'd2;

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_len_cnt;
    logic [GAP_W-1:0] r_gap_cnt;

    logic [W-1:0]     w_onehot;
    logic [W-1:0]     w_therm;
    logic [W-1:0]     w_pattern;
    logic [LEN_W-1:0] w_len_m1;
    logic             w_accept;

    // Thermometer bit k is set for every k up to and including the address.
    for (genvar k = 0; k < W; k++) begin : g_therm
        assign w_therm[k] = (N'(k) <= req_addr);
    end

    assign w_onehot = W'(1) << req_addr;

    // Select the decode style and derive the counter load (len 0 behaves as 1).
    always_comb begin
        w_pattern = req_mode ? w_therm : w_onehot;
        w_len_m1  = (req_len == '0) ? '0 : (req_len - LEN_W'(1));
    end

    // Held low during reset even though the state register already reads IDLE.
    assign req_ready = rst_n && enable && (r_state == c_IDLE);
    assign w_accept  = req_valid && req_ready;

    // Strobe sequencer: IDLE -> ACTIVE (len cycles) -> GAP (GAP_LEN cycles) -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_len_cnt <= '0;
            r_gap_cnt <= '0;
            y         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        y         <= w_pattern;
                        r_len_cnt <= w_len_m1;
                        r_state   <= c_ACTIVE;
                        busy      <= 1'b1;
                    end
                end
                c_ACTIVE: begin
                    if (!enable) begin
                        // Abort skips the gap entirely.
                        y       <= '0;
                        aborted <= 1'b1;
                        r_state <= c_IDLE;
                        busy    <= 1'b0;
                    end else if (r_len_cnt == '0) begin
                        y    <= '0;
                        done <= 1'b1;
                        if (GAP_LEN > 0) begin
                            // The done cycle is the first gap cycle.
                            r_state   <= c_GAP;
                            r_gap_cnt <= c_gap_load;
                        end else begin
                            r_state <= c_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_len_cnt <= r_len_cnt - LEN_W'(1);
                    end
                end
                c_GAP: begin
                    // enable is deliberately ignored here.
                    if (r_gap_cnt == '0) begin
                        r_state <= c_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    y       <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decoder_nbit_strobe.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_nbit_strobe
// Description : Directed bench for decoder_nbit_strobe. Two instances share
//               the stimulus: one with GAP_LEN=1, one with GAP_LEN=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_nbit_strobe;

    localparam int N     = 3;
    localparam int LEN_W = 8;
    localparam int W     = 2**N;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             req_valid;
    logic [N-1:0]     req_addr;
    logic             req_mode;
    logic [LEN_W-1:0] req_len;

    logic             ready_g1, busy_g1, done_g1, aborted_g1;
    logic [W-1:0]     y_g1;
    logic             ready_g0, busy_g0, done_g0, aborted_g0;
    logic [W-1:0]     y_g0;

    int total = 0;
    int bad   = 0;
    int done_count_g1 = 0;

    decoder_nbit_strobe #(.N(N), .LEN_W(LEN_W), .GAP_LEN(1)) u_dut_g1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .req_valid (req_valid),
        .req_ready (ready_g1),
        .req_addr  (req_addr),
        .req_mode  (req_mode),
        .req_len   (req_len),
        .y         (y_g1),
        .busy      (busy_g1),
        .done      (done_g1),
        .aborted   (aborted_g1)
    );

    decoder_nbit_strobe #(.N(N), .LEN_W(LEN_W), .GAP_LEN(0)) u_dut_g0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .req_valid (req_valid),
        .req_ready (ready_g0),
        .req_addr  (req_addr),
        .req_mode  (req_mode),
        .req_len   (req_len),
        .y         (y_g0),
        .busy      (busy_g0),
        .done      (done_g0),
        .aborted   (aborted_g0)
    );

    always #5 clk = ~clk;

    // Count done pulses of the gapped instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (done_g1) done_count_g1 <= done_count_g1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        rst_n     = 1'b0;
        enable    = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_mode  = 1'b0;
        req_len   = '0;
        repeat (3) cyc();
        check("rst_y",     32'(y_g1), 'h0);
        check("rst_ready", 32'(ready_g1), 'h0);
        rst_n  = 1'b1;
        enable = 1'b1;
        #1;
        check("ready_after_rst", 32'(ready_g1), 'h1);

        // Reset in the middle of a strobe.
        req_valid = 1'b1; req_addr = 3'd2; req_len = 8'd5; req_mode = 1'b0;
        cyc();
        req_valid = 1'b0;
        check("pre_rst_y", 32'(y_g1), 'h04);
        check("pre_rst_busy", 32'(busy_g1), 'h1);
        cyc();
        rst_n = 1'b0;
        #1;
        check("midrst_y",     32'(y_g1), 'h0);
        check("midrst_busy",  32'(busy_g1), 'h0);
        check("midrst_ready", 32'(ready_g1), 'h0);
        check("midrst_y_g0",  32'(y_g0), 'h0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        check("rel_ready", 32'(ready_g1), 'h1);

        // One-hot sweep, length 2, one gap cycle.
        base = done_count_g1;
        for (int a = 0; a < W; a++) begin
            req_valid = 1'b1; req_addr = 3'(a); req_len = 8'd2; req_mode = 1'b0;
            cyc();
            req_valid = 1'b0;
            check("oh_c1",   32'(y_g1), 32'(1 << a));
            check("oh_c1_d", 32'(done_g1), 'h0);
            cyc();
            check("oh_c2",   32'(y_g1), 32'(1 << a));
            cyc();
            check("oh_gap_y", 32'(y_g1), 'h0);
            check("oh_done",  32'(done_g1), 'h1);
            check("oh_gap_busy", 32'(busy_g1), 'h1);
            check("oh_gap_ready", 32'(ready_g1), 'h0);
            cyc();
            check("oh_idle_ready", 32'(ready_g1), 'h1);
            check("oh_idle_busy",  32'(busy_g1), 'h0);
        end
        #5;
        check("oh_done_count", 32'(done_count_g1 - base), 'd8);

        // Thermometer, addr 5, length 3.
        req_valid = 1'b1; req_addr = 3'd5; req_len = 8'd3; req_mode = 1'b1;
        cyc();
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("th5_y", 32'(y_g1), 'h3F);
            cyc();
        end
        check("th5_end_y", 32'(y_g1), 'h0);
        check("th5_done",  32'(done_g1), 'h1);
        cyc();
        // Thermometer, top address, length 1.
        req_valid = 1'b1; req_addr = 3'd7; req_len = 8'd1; req_mode = 1'b1;
        cyc();
        req_valid = 1'b0;
        check("th7_y", 32'(y_g1), 'hFF);
        cyc();
        check("th7_done", 32'(done_g1), 'h1);
        check("th7_end_y", 32'(y_g1), 'h0);
        cyc();

        // Zero length, back to back, no gap (GAP_LEN=0 instance).
        req_valid = 1'b1; req_addr = 3'd1; req_len = 8'd0; req_mode = 1'b0;
        cyc();
        req_addr = 3'd6;
        #1;
        check("b2b_y1",     32'(y_g0), 'h02);
        check("b2b_ready1", 32'(ready_g0), 'h0);
        cyc();
        check("b2b_gap_y",  32'(y_g0), 'h0);
        check("b2b_done",   32'(done_g0), 'h1);
        check("b2b_ready2", 32'(ready_g0), 'h1);
        cyc();
        req_valid = 1'b0;
        check("b2b_y2",     32'(y_g0), 'h40);
        check("b2b_done2",  32'(done_g0), 'h0);
        check("g1_no_accept", 32'(y_g1), 'h0);
        cyc();
        check("b2b_done3",  32'(done_g0), 'h1);
        cyc();

        // Abort after four active cycles.
        req_valid = 1'b1; req_addr = 3'd3; req_len = 8'd10; req_mode = 1'b0;
        cyc();
        req_valid = 1'b0;
        repeat (3) cyc();
        check("ab_c4_y", 32'(y_g1), 'h08);
        enable = 1'b0;
        cyc();
        check("ab_y",       32'(y_g1), 'h0);
        check("ab_aborted", 32'(aborted_g1), 'h1);
        check("ab_done",    32'(done_g1), 'h0);
        check("ab_busy",    32'(busy_g1), 'h0);
        check("ab_ready",   32'(ready_g1), 'h0);
        check("ab_aborted_g0", 32'(aborted_g0), 'h1);
        cyc();
        check("ab_pulse_end", 32'(aborted_g1), 'h0);
        check("ab_no_done",   32'(done_g1), 'h0);
        check("ab_ready_off", 32'(ready_g1), 'h0);
        // Pending request is held off while disabled.
        req_valid = 1'b1; req_addr = 3'd4; req_len = 8'd3; req_mode = 1'b0;
        cyc();
        check("dis_hold_y",    32'(y_g1), 'h0);
        check("dis_hold_busy", 32'(busy_g1), 'h0);
        enable = 1'b1;
        #1;
        check("ab_ready_back", 32'(ready_g1), 'h1);

        // Handshake stability: request inputs change mid-strobe.
        cyc();
        req_addr = 3'd0; req_len = 8'd1; req_mode = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stab_y",     32'(y_g1), 'h10);
            check("stab_ready", 32'(ready_g1), 'h0);
            cyc();
        end
        check("stab_done",  32'(done_g1), 'h1);
        check("stab_end_y", 32'(y_g1), 'h0);
        cyc();
        check("stab_idle_y",     32'(y_g1), 'h0);
        check("stab_idle_ready", 32'(ready_g1), 'h1);
        check("stab_idle_busy",  32'(busy_g1), 'h0);
        cyc();
        req_valid = 1'b0;
        check("stab_second_y",    32'(y_g1), 'h01);
        check("stab_second_busy", 32'(busy_g1), 'h1);
        cyc();
        check("stab_second_done", 32'(done_g1), 'h1);
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decoder_nbit_strobe.md
Name: decoder_nbit_strobe

Overview:
- Registered, parametrised successor to the combinational N-bit decoder.
- Accepts a decode request (address, mode, length) over a valid/ready handshake and drives the decoded pattern on y for a programmable number of cycles. It then enforces a fixed inter-strobe gap before accepting the next request.
- Used as a timed chip-select / strobe generator in front of banked peripherals.
- Supports one-hot and thermometer decode modes, an abort via enable, and done/abort status pulses.

Parameters:
- N, 3, address width; output width is 2**N.
- LEN_W, 8, width of the request length field.
- GAP_LEN, 1, idle cycles forced after each strobe with y=0; 0 means no gap.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  block enable; 0 blocks acceptance and aborts any strobe in progress.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_addr  input  N  index to decode.
- req_mode  input  1  0 = one-hot, 1 = thermometer.
- req_len  input  LEN_W  strobe length in cycles; 0 is treated as 1.
- y  output  2**N  registered decoded pattern.
- busy  output  1  high in ACTIVE or GAP.
- done  output  1  one-cycle pulse when a strobe completes normally.
- aborted  output  1  one-cycle pulse when a strobe is cut short by enable=0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, y=0, busy=0, done=0, aborted=0, counters=0. req_ready=0 while rst_n=0.
- req_ready is combinational: (state==IDLE) && enable. Accept occurs at a rising edge with req_valid && req_ready.
- Decode:
  - one-hot: y = 1 << addr.
  - thermometer: y[k] = 1 for all k <= addr, else 0. addr=2**N-1 gives all ones.
- L = (req_len==0) ? 1 : req_len. Length is captured at accept; later changes to the req_* inputs are ignored.
- State machine:
  - IDLE: y=0. On accept: y takes the decoded pattern at that same edge (pattern visible the cycle after accept), length counter loads L-1, go to ACTIVE.
  - ACTIVE: y holds the pattern for exactly L cycles total.
    - When the counter reaches 0 and enable=1: y=0 and done=1 for the next cycle. Go to GAP if GAP_LEN>0, else go to IDLE.
    - If enable=0 on any ACTIVE edge: y=0 and aborted=1 for the next cycle, go directly to IDLE. No gap is applied and done stays 0.
  - GAP: y=0 for GAP_LEN cycles, then IDLE. enable=0 during GAP does not shorten it, and it does not pulse aborted.
- busy = 1 in ACTIVE and GAP, else 0. busy is registered along with the state.
- done and aborted are registered, each high for exactly one cycle, and mutually exclusive.
- Back-to-back with GAP_LEN=0: req_ready rises in the cycle done is high, so a new request can be accepted then. The minimum period between strobe starts is L+1 cycles.
- Mid-operation reset: all outputs return to reset values immediately; the in-flight request is lost.
- enable=0 in IDLE: req_ready=0 and a pending req_valid is held off; nothing else changes.
- No combinational path from req_* to y. y changes only on clock edges or async reset.

Test Plan:
- Reset, N=3, GAP_LEN=1: assert rst_n=0 mid-strobe (y=8'b0000_0100) -> y=0, busy=0, req_ready=0 immediately. After release with enable=1 -> req_ready=1.
- One-hot sweep: addr 0..7, len=2, mode=0, enable=1 -> y=1<<addr for exactly 2 cycles each, then 1 gap cycle with y=0. done pulses once per request; 8 done pulses total.
- Thermometer: addr=5, len=3, mode=1 -> y=8'b0011_1111 for 3 cycles, then done=1 with y=0. addr=7 -> y=8'hFF.
- Length zero and back-to-back: GAP_LEN=0, two requests with len=0, addr=1 then addr=6, req_valid held high -> y=8'h02 for 1 cycle, then 0 for 1 cycle (done), then 8'h40 for 1 cycle. Starts are 2 cycles apart.
- Abort: len=10, addr=3; drop enable after cycle 4 of ACTIVE -> the next cycle has y=0, aborted=1, done=0, state IDLE, and no gap. req_ready stays 0 until enable returns to 1.
- Handshake stability: change req_addr and req_len during ACTIVE, and hold req_valid=1 throughout -> y is unchanged. The second request is accepted only once req_ready=1 in IDLE.
